// File: rtl/stream_source_gen.sv
// Valid/ready stream source: fixed-length bursts of incrementing or Galois-LFSR
// data with a last marker, an idle gap between bursts and a completed-burst counter.
module stream_source_gen #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic [63:0] START_VAL  = 64'd1,
  parameter logic [63:0] STEP       = 64'd1,
  parameter logic [63:0] POLY       = 64'hB8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              last,
  output logic [CNT_W-1:0]  burst_cnt
);

  localparam int unsigned IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DATA_W-1:0] START_W  = START_VAL[DATA_W-1:0];
  localparam logic [DATA_W-1:0] STEP_W   = STEP[DATA_W-1:0];
  localparam logic [DATA_W-1:0] POLY_W   = POLY[DATA_W-1:0];
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BURST_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic              FIRST_LAST = (BURST_LEN == 1);
  localparam logic              HAS_GAP    = (GAP_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  // The LFSR can never run from an all-zero state; substitute 1.
  function automatic logic [DATA_W-1:0] seed_fix(input logic [DATA_W-1:0] v, input logic m);
    return (m && (v == '0)) ? DATA_W'(1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v, input logic m);
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] n;
    x = seed_fix(v, m);
    if (m) begin
      n = (x >> 1) ^ (x[0] ? POLY_W : '0);
      n = seed_fix(n, 1'b1);
    end else begin
      n = v + STEP_W;
    end
    return n;
  endfunction

  state_t            state_q, state_d;
  logic [DATA_W-1:0] gen_q, gen_d;
  logic              mode_q, mode_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] gen_adv_c;
  logic [DATA_W-1:0] start_val_c;
  logic [DATA_W-1:0] chain_val_c;
  logic              start_c;

  assign gen_adv_c   = advance(gen_q, mode_q);
  assign start_val_c = seed_fix(gen_q, mode);
  assign chain_val_c = seed_fix(gen_adv_c, mode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gen_q   <= START_W;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gen_q   <= gen_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    gen_d   = gen_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    start_c = 1'b0;

    case (state_q)
      IDLE: start_c = en;
      SEND: begin
        if (valid_q && ready) begin
          gen_d = gen_adv_c;
          if (!last_q) begin
            idx_d  = idx_q + IDX_W'(1);
            data_d = gen_adv_c;
            last_d = ((idx_q + IDX_W'(1)) == LAST_IDX);
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            valid_d = 1'b0;
            last_d  = 1'b0;
            idx_d   = '0;
            gap_d   = '0;
            if (HAS_GAP) begin
              state_d = GAP;
            end else if (en) begin
              // Zero-gap chaining: next burst starts with no bubble.
              mode_d  = mode;
              gen_d   = chain_val_c;
              data_d  = chain_val_c;
              valid_d = 1'b1;
              last_d  = FIRST_LAST;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (en) start_c = 1'b1;
          else    state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_c) begin
      state_d = SEND;
      mode_d  = mode;
      gen_d   = start_val_c;
      data_d  = start_val_c;
      valid_d = 1'b1;
      last_d  = FIRST_LAST;
      idx_d   = '0;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign last      = last_q;
  assign burst_cnt = cnt_q;

endmodule

// File: tb/tb_stream_source_gen.sv
// Scoreboard bench for stream_source_gen: default, wrap/zero-gap and 8-bit LFSR instances.
module tb_stream_source_gen;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready = 1'b1;
  logic en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;
  logic mode0 = 1'b0, mode1 = 1'b0, mode2 = 1'b1;
  logic [31:0] data0, data1;
  logic [7:0]  data2;
  logic valid0, valid1, valid2, last0, last1, last2;
  logic [15:0] cnt0, cnt1, cnt2;

  int vec_cnt = 0;
  int err_cnt = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  stream_source_gen #(.DATA_W(32), .BURST_LEN(4), .GAP_CYCLES(2), .START_VAL(64'd1),
                      .STEP(64'd1), .POLY(64'hB8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .en(en0), .mode(mode0), .data(data0), .valid(valid0),
    .ready(ready), .last(last0), .burst_cnt(cnt0));

  stream_source_gen #(.DATA_W(32), .BURST_LEN(4), .GAP_CYCLES(0), .START_VAL(64'hFFFF_FFFE),
                      .STEP(64'd1), .POLY(64'hB8), .CNT_W(16)) u_wrap (
    .clk(clk), .rst(rst), .en(en1), .mode(mode1), .data(data1), .valid(valid1),
    .ready(ready), .last(last1), .burst_cnt(cnt1));

  stream_source_gen #(.DATA_W(8), .BURST_LEN(4), .GAP_CYCLES(2), .START_VAL(64'd1),
                      .STEP(64'd1), .POLY(64'hB8), .CNT_W(16)) u_lfsr (
    .clk(clk), .rst(rst), .en(en2), .mode(mode2), .data(data2), .valid(valid2),
    .ready(ready), .last(last2), .burst_cnt(cnt2));

  task automatic push(input logic [31:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    mode0 = 1'b0; mode1 = 1'b0; mode2 = 1'b1;
    ready = 1'b1;
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({valid0, last0} !== 2'b00 || data0 !== 32'd0 || cnt0 !== 16'd0) begin
      err_cnt++;
      $display("FAIL reset_dut: valid=%b last=%b data=%h cnt=%0d, required all 0", valid0, last0, data0, cnt0);
    end
    vec_cnt++;
    if ({valid1, valid2} !== 2'b00 || data1 !== 32'd0 || data2 !== 8'd0 || cnt1 !== 16'd0 || cnt2 !== 16'd0) begin
      err_cnt++;
      $display("FAIL reset_others: v1=%b v2=%b d1=%h d2=%h, required all 0", valid1, valid2, data1, data2);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (valid0 !== 1'b0) begin
        err_cnt++;
        $display("FAIL idle_no_en: cycle %0d valid=%b, required 0", i, valid0);
      end
    end
  endtask

  task automatic test_free_run();
    beat_t b;
    int seen = 0;
    int gap = 0;
    logic [15:0] exp_cnt = 16'd0;
    do_reset();
    for (int i = 1; i <= 8; i++) push(32'(i), (i % 4) == 0);
    en0 = 1'b1;
    for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      vec_cnt++;
      if (cnt0 !== exp_cnt) begin
        err_cnt++;
        $display("FAIL free_cnt: burst_cnt=%0d, required %0d", cnt0, exp_cnt);
      end
      if (valid0) begin
        b = exp_q.pop_front();
        vec_cnt++;
        if (data0 !== b.d || last0 !== b.l) begin
          err_cnt++;
          $display("FAIL free_beat: data=%h last=%b, required data=%h last=%b", data0, last0, b.d, b.l);
        end
        if (seen == 4) begin
          vec_cnt++;
          if (gap != 2) begin
            err_cnt++;
            $display("FAIL free_gap: %0d idle cycles, required 2", gap);
          end
        end
        seen++;
        gap = 0;
        if (b.l) exp_cnt++;
        if (exp_q.size() == 0) en0 = 1'b0;
      end else if (seen > 0) begin
        gap++;
      end
    end
    if (exp_q.size() != 0) begin
      vec_cnt++; err_cnt++;
      $display("FAIL free_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    vec_cnt++;
    if (cnt0 !== 16'd2) begin
      err_cnt++;
      $display("FAIL free_cnt_end: burst_cnt=%0d, required 2", cnt0);
    end
  endtask

  task automatic test_backpressure();
    beat_t b;
    int popped = 0;
    int hold = 0;
    logic inb = 1'b0;
    do_reset();
    for (int i = 1; i <= 4; i++) push(32'(i), i == 4);
    en0 = 1'b1;
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      ready = 1'b1;
      if (inb) begin
        vec_cnt++;
        if (valid0 !== 1'b1) begin
          err_cnt++;
          $display("FAIL bp_valid_drop: valid=%b mid-burst, required 1", valid0);
        end
      end
      if (valid0) begin
        en0 = 1'b0;
        if (popped == 1 && hold < 3) begin
          ready = 1'b0;
          hold++;
          vec_cnt++;
          if (data0 !== exp_q[0].d || last0 !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_hold: data=%h last=%b, required data=%h last=0", data0, last0, exp_q[0].d);
          end
        end else begin
          b = exp_q.pop_front();
          popped++;
          inb = !b.l;
          vec_cnt++;
          if (data0 !== b.d || last0 !== b.l) begin
            err_cnt++;
            $display("FAIL bp_beat: data=%h last=%b, required data=%h last=%b", data0, last0, b.d, b.l);
          end
        end
      end
    end
    ready = 1'b1;
    if (exp_q.size() != 0) begin
      vec_cnt++; err_cnt++;
      $display("FAIL bp_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_en_drop();
    beat_t b;
    int popped = 0;
    do_reset();
    for (int i = 1; i <= 4; i++) push(32'(i), i == 4);
    en0 = 1'b1;
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (valid0) begin
        b = exp_q.pop_front();
        popped++;
        if (popped == 2) en0 = 1'b0;
        vec_cnt++;
        if (data0 !== b.d || last0 !== b.l) begin
          err_cnt++;
          $display("FAIL endrop_beat: data=%h last=%b, required data=%h last=%b", data0, last0, b.d, b.l);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (valid0 !== 1'b0) begin
        err_cnt++;
        $display("FAIL endrop_idle: cycle %0d valid=%b, required 0", i, valid0);
      end
    end
    for (int i = 5; i <= 8; i++) push(32'(i), i == 8);
    en0 = 1'b1;
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (valid0) begin
        en0 = 1'b0;
        b = exp_q.pop_front();
        vec_cnt++;
        if (data0 !== b.d || last0 !== b.l) begin
          err_cnt++;
          $display("FAIL endrop_resume: data=%h last=%b, required data=%h last=%b", data0, last0, b.d, b.l);
        end
      end
    end
    if (exp_q.size() != 0) begin
      vec_cnt++; err_cnt++;
      $display("FAIL endrop_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    vec_cnt++;
    if (cnt0 !== 16'd2) begin
      err_cnt++;
      $display("FAIL endrop_cnt: burst_cnt=%0d, required 2", cnt0);
    end
  endtask

  task automatic test_wrap();
    beat_t b;
    logic started = 1'b0;
    do_reset();
    push(32'hFFFF_FFFE, 1'b0); push(32'hFFFF_FFFF, 1'b0);
    push(32'h0000_0000, 1'b0); push(32'h0000_0001, 1'b1);
    push(32'h0000_0002, 1'b0); push(32'h0000_0003, 1'b0);
    push(32'h0000_0004, 1'b0); push(32'h0000_0005, 1'b1);
    en1 = 1'b1;
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (started) begin
        vec_cnt++;
        if (valid1 !== 1'b1) begin
          err_cnt++;
          $display("FAIL wrap_bubble: valid=%b, required 1", valid1);
        end
      end
      if (valid1) begin
        started = 1'b1;
        b = exp_q.pop_front();
        vec_cnt++;
        if (data1 !== b.d || last1 !== b.l) begin
          err_cnt++;
          $display("FAIL wrap_beat: data=%h last=%b, required data=%h last=%b", data1, last1, b.d, b.l);
        end
        if (exp_q.size() == 0) en1 = 1'b0;
      end
    end
    if (exp_q.size() != 0) begin
      vec_cnt++; err_cnt++;
      $display("FAIL wrap_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    vec_cnt++;
    if (cnt1 !== 16'd2 || valid1 !== 1'b0) begin
      err_cnt++;
      $display("FAIL wrap_end: burst_cnt=%0d valid=%b, required 2 and 0", cnt1, valid1);
    end
  endtask

  task automatic test_lfsr();
    beat_t b;
    int popped = 0;
    logic [7:0] seq [12] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1, 8'hC8,
                             8'h64, 8'h65, 8'h66, 8'h67};
    do_reset();
    for (int i = 0; i < 12; i++) push({24'd0, seq[i]}, (i % 4) == 3);
    en2 = 1'b1;
    for (int cyc = 0; cyc < 80 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (valid2) begin
        b = exp_q.pop_front();
        popped++;
        if (popped == 2) mode2 = 1'b0;
        if (popped == 3) mode2 = 1'b1;
        if (popped == 5) mode2 = 1'b0;
        vec_cnt++;
        if ({24'd0, data2} !== b.d || last2 !== b.l) begin
          err_cnt++;
          $display("FAIL lfsr_beat %0d: data=%h last=%b, required data=%h last=%b", popped, data2, last2, b.d[7:0], b.l);
        end
        if (exp_q.size() == 0) en2 = 1'b0;
      end
    end
    if (exp_q.size() != 0) begin
      vec_cnt++; err_cnt++;
      $display("FAIL lfsr_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    beat_t b;
    do_reset();
    for (int i = 1; i <= 6; i++) push(32'(i), i == 4);
    en0 = 1'b1;
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (valid0) begin
        b = exp_q.pop_front();
        vec_cnt++;
        if (data0 !== b.d || last0 !== b.l) begin
          err_cnt++;
          $display("FAIL rstmid_beat: data=%h last=%b, required data=%h last=%b", data0, last0, b.d, b.l);
        end
      end
    end
    if (exp_q.size() != 0) begin
      vec_cnt++; err_cnt++;
      $display("FAIL rstmid_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    vec_cnt++;
    if (valid0 !== 1'b1 || data0 !== 32'd7 || cnt0 !== 16'd1) begin
      err_cnt++;
      $display("FAIL rstmid_pre: valid=%b data=%h cnt=%0d, required 1 7 1", valid0, data0, cnt0);
    end
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (valid0 !== 1'b0 || data0 !== 32'd0 || last0 !== 1'b0 || cnt0 !== 16'd0) begin
      err_cnt++;
      $display("FAIL rstmid_async: valid=%b data=%h last=%b cnt=%0d, required all 0", valid0, data0, last0, cnt0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) push(32'(i), i == 4);
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (valid0) begin
        en0 = 1'b0;
        b = exp_q.pop_front();
        vec_cnt++;
        if (data0 !== b.d || last0 !== b.l) begin
          err_cnt++;
          $display("FAIL rstmid_restart: data=%h last=%b, required data=%h last=%b", data0, last0, b.d, b.l);
        end
      end
    end
    if (exp_q.size() != 0) begin
      vec_cnt++; err_cnt++;
      $display("FAIL rstmid_restart_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_backpressure();
    test_en_drop();
    test_wrap();
    test_lfsr();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/stream_source_gen.md
# stream_source_gen

Parametrised valid/ready stream source: the next generation of the team's fixed 32-bit incrementing master. It emits fixed-length bursts of generated data words (incrementing or LFSR pattern) with a `last` marker, holds every beat stable under backpressure, inserts a configurable idle gap between bursts, and counts completed bursts. It sits at the head of handshake test chains as the traffic generator feeding slave/FIFO blocks.

## Interface
Parameters:
- `DATA_W`, 32: data width, 2..64.
- `BURST_LEN`, 8: beats per burst, ≥1.
- `GAP_CYCLES`, 2: valid-low cycles between bursts, ≥0.
- `START_VAL`, 1: first data value after reset (truncated to DATA_W).
- `STEP`, 1: increment per beat in mode 0.
- `POLY`, 'hB8: Galois LFSR tap mask, mode 1 (DATA_W bits).
- `CNT_W`, 16: burst counter width.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  enable; new bursts start only while high.
- `mode`  in  1  0 = incrementing, 1 = LFSR; sampled at burst start.
- `data`  out  DATA_W  beat payload.
- `valid`  out  1  beat present.
- `ready`  in  1  sink accepts the beat.
- `last`  out  1  high on the final beat of a burst.
- `burst_cnt`  out  CNT_W  completed bursts, wraps at 2^CNT_W.

## Operation
- All outputs are registered. Reset values: `valid`=0, `data`=0, `last`=0, `burst_cnt`=0, state IDLE, beat index 0, generator = START_VAL (LFSR seed forced to 1 if START_VAL truncates to 0).
- Handshake: beat transfers on a rising edge with `valid`&&`ready`. Once `valid` is high, `valid`, `data`, and `last` stay unchanged until the transfer. `valid` never drops mid-burst.
- FSM states:
  - IDLE: `valid`=0. If `en`=1: latch `mode`, go to SEND, `valid`=1, `data`=generator, `last`=(BURST_LEN==1).
  - SEND: on a transfer, advance the generator and beat index.
    - Non-final beat: present the next value, `last` high when index==BURST_LEN-1.
    - Final beat: `burst_cnt`+1.
      - GAP_CYCLES>0: go to GAP, `valid`=0.
      - GAP_CYCLES==0 and `en`=1: stay in SEND, relatch `mode`, present the next beat with no bubble.
      - Otherwise: go to IDLE.
  - GAP: `valid`=0 for exactly GAP_CYCLES cycles, then behave as IDLE (start immediately if `en`=1, else go to IDLE).
- `en` falling mid-burst: the current burst completes in full, then the gap runs, then IDLE.
- `mode` changes mid-burst are ignored until the next burst start.
- Generator, mode 0: next = current + STEP, mod 2^DATA_W, wraps silently.
- Generator, mode 1: Galois right shift, next = (cur>>1) ^ (cur[0] ? POLY : 0). A zero state is replaced by 1.
- The generator continues across bursts and is never reset by `en`. Only `rst` reloads START_VAL.
- `rst` mid-burst: outputs clear immediately (asynchronous). The partial burst is discarded and not counted.

## Timing
- `en` high at edge N in IDLE (or final gap cycle): `valid`=1 after edge N.
- Back-to-back beats: with `ready` held high, one beat per cycle within a burst.
- Burst period with `ready`=1: BURST_LEN + GAP_CYCLES cycles.
- Transfer at edge N: next `data` is visible after edge N, with no combinational path from `ready` to outputs.
- `burst_cnt` updates on the same edge as the final-beat transfer.
- Reset release: the first `valid` is no earlier than one cycle after the first edge sampling `en`=1.

## Test plan
Defaults for all scenarios: DATA_W=32, BURST_LEN=4, GAP_CYCLES=2, START_VAL=1, STEP=1, mode 0.

1. Free run, `en`=1, `ready`=1 → `data` 1,2,3,4 with `last` on 4; then 2 cycles `valid`=0; then 5,6,7,8; `burst_cnt` 1 then 2.
2. Backpressure: `ready`=0 for 3 cycles while beat 2 is shown → `data`=2, `valid`=1, `last`=0 held for all 3 cycles; beat 3 appears the cycle after `ready` returns.
3. `en` dropped after beat 2 transfers → beats 3,4 still sent (`last` on 4); gap; `valid` stays 0 in IDLE. Re-raise `en` → next burst starts at 5.
4. Wrap: START_VAL='hFFFF_FFFE → sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001. GAP_CYCLES=0 variant: burst 2 follows with no bubble.
5. LFSR: DATA_W=8, POLY='hB8, START_VAL=1, mode=1 → 01, B8, 5C, 2E, 17, B3. Toggling `mode` mid-burst has no effect until the next burst.
6. `rst` pulsed mid-burst with `valid`=1 → `valid`, `data`, `last`, and `burst_cnt` read 0 before the next clock edge. After release with `en`=1, data restarts at 1.
